chan_acq_responder: RTL and testbench
=====================================

CHAN_ACQ_RESPONDER -- requirements
Module: chan_acq_responder

Interface
REQ-001 SHALL have parameter NSAMP, default 16, samples captured per trigger; power of 2, range 2..1024.
REQ-002 SHALL have parameter DONE_CYCLES, default 4, cycles `done` is held high; range 1..255.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port acq_trig, input, 1, trigger from master FPGA; asynchronous to clk.
REQ-006 SHALL have port adc_data, input, 32, sample word, valid every cycle.
REQ-007 SHALL have port m_axis_tdata, output, 32, AXI4-Stream data toward the Aurora TX FIFO.
REQ-008 SHALL have port m_axis_tvalid, output, 1, stream valid.
REQ-009 SHALL have port m_axis_tlast, output, 1, last word of event.
REQ-010 SHALL have port m_axis_tready, input, 1, downstream ready.
REQ-011 SHALL have port done, output, 1, acquisition-complete level returned to master.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-013 SHALL have port trig_count, output, 24, number of accepted triggers.
REQ-014 SHALL have port trig_missed, output, 1, sticky flag for triggers dropped while busy.

Function
REQ-015 SHALL pass acq_trig through a 2-flop synchronizer, then a registered rising-edge detector.
REQ-016 SHALL implement FSM states IDLE, CAPTURE, SEND_HDR, SEND_DATA, SEND_TRL, DONE.
REQ-017 SHALL leave IDLE for CAPTURE no later than 3 clk edges after acq_trig rises, provided acq_trig stays high at least 2 cycles.
REQ-018 SHALL increment trig_count (24-bit, wraps FFFFFF->000000) on the same edge that leaves IDLE.
REQ-019 SHALL, in CAPTURE, write adc_data into an NSAMP-deep buffer on NSAMP consecutive edges, independent of m_axis_tready, then enter SEND_HDR.
REQ-020 SHALL emit the header word {8'hA5, trig_count} in SEND_HDR, using the incremented value.
REQ-021 SHALL emit buffered samples in SEND_DATA in capture order, advancing one word per edge with tvalid&&tready.
REQ-022 SHALL hold tdata, tvalid and tlast stable while tvalid=1 and tready=0; tvalid SHALL NOT depend combinationally on tready.
REQ-023 SHALL deassert tvalid in IDLE, CAPTURE and DONE.
REQ-024 SHALL emit exactly NSAMP+1 words per event, or NSAMP+2 with the trailer (REQ-034), with no gaps while tready=1.
REQ-025 SHALL assert tlast only on the final word of each event.
REQ-026 SHALL enter DONE after the final handshake and hold done=1 for exactly DONE_CYCLES cycles, then return to IDLE.
REQ-027 SHALL ignore rising edges detected outside IDLE and set trig_missed; trig_missed SHALL clear only on reset.
REQ-028 SHALL treat a rising edge detected on the same edge as the DONE->IDLE transition as missed.
REQ-029 SHALL NOT re-trigger on a held-high acq_trig; a new low-to-high transition is required.

Reset
REQ-030 SHALL, while rst_n=0, immediately force: state IDLE; tvalid, tlast, done, busy and trig_missed 0; tdata 0; trig_count 0; synchronizer 0.
REQ-031 SHALL abandon any partial event on mid-operation reset; no tlast is issued for it.
REQ-032 SHALL release reset without a spurious trigger, even if acq_trig is already high.

Configuration
REQ-033 SHALL use macro CHAN_ACQ_TRAILER_EN to compile in the SEND_TRL state.
REQ-034 SHALL, with the macro defined, append the trailer word equal to the XOR of the header and all samples; tlast moves to the trailer.
REQ-035 SHALL, without the macro, skip SEND_TRL from SEND_DATA to DONE, with tlast on the last sample.

Verification
REQ-036 Reset, then acq_trig pulse 4 cycles, adc_data=counter starting at 0x100, tready=1 -> header 0xA5000001, samples 0x100+k captured order, 17 words (18 with trailer), tlast last, done high 4 cycles.
REQ-037 tready toggling 1-0-0-1 during SEND_DATA -> no word lost or duplicated, tdata stable while stalled.
REQ-038 Second acq_trig edge during SEND_DATA -> event unaffected, trig_missed=1, trig_count stays 1.
REQ-039 Preload trig_count at 0xFFFFFF via 2^24-1 triggers (or force), then trigger -> header 0xA5000000.
REQ-040 rst_n low mid SEND_DATA -> tvalid 0 immediately, all outputs at reset values; acq_trig held high across release -> no event.
REQ-041 Trailer build, samples 1..16 -> trailer = 0xA5000001 ^ XOR(1..16) = 0xA5000011.

Source files
------------

// File: rtl/chan_acq_responder_if.sv
// AXI4-Stream link from the acquisition responder toward the Aurora TX FIFO.
// master: drives tdata/tvalid/tlast, samples tready; slave: the reverse.
interface chan_acq_responder_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/chan_acq_responder.sv
// Channel acquisition responder: on each trigger from the master FPGA,
// captures NSAMP ADC words and streams {header, samples[, trailer]}.
// Ports: clk, rst_n (async, active low), acq_trig (async trigger),
// adc_data (sample every cycle), m_axis (stream master), done (complete
// level, DONE_CYCLES long), busy (not idle), trig_count (accepted
// triggers), trig_missed (sticky, triggers dropped while busy).
// Option: define CHAN_ACQ_TRAILER_EN to append an XOR trailer word.
module chan_acq_responder #(
  parameter int NSAMP       = 16,
  parameter int DONE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       acq_trig,
  input  logic [31:0]                adc_data,
  chan_acq_responder_if.master       m_axis,
  output logic                       done,
  output logic                       busy,
  output logic [23:0]                trig_count,
  output logic                       trig_missed
);

  localparam int IW = $clog2(NSAMP);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NSAMP - 1);
  localparam logic [7:0]    DONE_LAST = 8'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SEND_HDR,
    SEND_DATA,
`ifdef CHAN_ACQ_TRAILER_EN
    SEND_TRL,
`endif
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic        prev_q, prev_d;
  logic [1:0]  settle_q, settle_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [23:0] trig_cnt_q, trig_cnt_d;
  logic        missed_q, missed_d;
`ifdef CHAN_ACQ_TRAILER_EN
  logic [31:0] acc_q, acc_d;
`endif

  logic [31:0] smp_mem [NSAMP];
  logic        wr_en;
  logic        rise;
  logic [31:0] hdr;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;

  // The edge detector stays disarmed (prev forced high) until the
  // synchronizer has refilled after reset, so a trigger already high
  // at reset release is not mistaken for a new rising edge.
  assign settle_d = {settle_q[0], 1'b1};
  assign prev_d   = settle_q[1] ? sync2_q : 1'b1;
  assign rise     = settle_q[1] & sync2_q & ~prev_q;

  assign hdr = {8'hA5, trig_cnt_q};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dcnt_d     = dcnt_q;
    trig_cnt_d = trig_cnt_q;
    missed_d   = missed_q;
`ifdef CHAN_ACQ_TRAILER_EN
    acc_d      = acc_q;
`endif
    wr_en      = 1'b0;
    tvalid     = 1'b0;
    tlast      = 1'b0;
    tdata      = '0;

    if (rise && (state_q != IDLE)) begin
      missed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = CAPTURE;
          trig_cnt_d = trig_cnt_q + 24'd1;
          idx_d      = '0;
`ifdef CHAN_ACQ_TRAILER_EN
          acc_d      = '0;
`endif
        end
      end

      CAPTURE: begin
        wr_en = 1'b1;
`ifdef CHAN_ACQ_TRAILER_EN
        acc_d = acc_q ^ adc_data;
`endif
        if (idx_q == LAST_IDX) begin
          state_d = SEND_HDR;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      SEND_HDR: begin
        tvalid = 1'b1;
        tdata  = hdr;
        if (m_axis.tready) begin
          state_d = SEND_DATA;
        end
      end

      SEND_DATA: begin
        tvalid = 1'b1;
        tdata  = smp_mem[idx_q];
`ifndef CHAN_ACQ_TRAILER_EN
        tlast  = (idx_q == LAST_IDX);
`endif
        if (m_axis.tready) begin
          if (idx_q == LAST_IDX) begin
`ifdef CHAN_ACQ_TRAILER_EN
            state_d = SEND_TRL;
`else
            state_d = DONE;
`endif
            dcnt_d  = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

`ifdef CHAN_ACQ_TRAILER_EN
      SEND_TRL: begin
        tvalid = 1'b1;
        tlast  = 1'b1;
        tdata  = hdr ^ acc_q;
        if (m_axis.tready) begin
          state_d = DONE;
          dcnt_d  = '0;
        end
      end
`endif

      DONE: begin
        if (dcnt_q == DONE_LAST) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b1;
      settle_q   <= '0;
      idx_q      <= '0;
      dcnt_q     <= '0;
      trig_cnt_q <= '0;
      missed_q   <= 1'b0;
`ifdef CHAN_ACQ_TRAILER_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= acq_trig;
      sync2_q    <= sync1_q;
      prev_q     <= prev_d;
      settle_q   <= settle_d;
      idx_q      <= idx_d;
      dcnt_q     <= dcnt_d;
      trig_cnt_q <= trig_cnt_d;
      missed_q   <= missed_d;
`ifdef CHAN_ACQ_TRAILER_EN
      acc_q      <= acc_d;
`endif
    end
  end

  // Sample store has no reset: contents are only read after a full
  // capture has overwritten every entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      smp_mem[idx_q] <= adc_data;
    end
  end

  assign m_axis.tdata  = tdata;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = tlast;

  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign trig_count  = trig_cnt_q;
  assign trig_missed = missed_q;

endmodule

// File: tb/tb_chan_acq_responder.sv
// Scoreboard bench for chan_acq_responder: random samples and tready,
// expected stream words built from observed capture windows.
module tb_chan_acq_responder;
  localparam int NSAMP = 16;
  localparam int DC    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acq_trig = 1'b0;
  logic [31:0] adc_data = '0;
  logic        done, busy, trig_missed;
  logic [23:0] trig_count;

  chan_acq_responder_if m_axis ();

  chan_acq_responder #(
    .NSAMP       (NSAMP),
    .DONE_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .acq_trig    (acq_trig),
    .adc_data    (adc_data),
    .m_axis      (m_axis),
    .done        (done),
    .busy        (busy),
    .trig_count  (trig_count),
    .trig_missed (trig_missed)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model state
  logic [23:0] model_cnt = '0;
  logic [23:0] hdrq [$];
  logic [32:0] expq [$];
  logic [31:0] cur [$];
  bit          mon_en = 1'b0;

  // stimulus drivers
  bit          adc_ctr_mode = 1'b0;
  logic [31:0] adc_ctr = 32'h100;
  int          rdy_mode = 0;
  logic [3:0]  pat = 4'b1001;
  int          pat_i = 0;

  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (adc_ctr_mode) begin
        adc_data = adc_ctr;
        adc_ctr  = adc_ctr + 1;
      end else begin
        adc_data = $urandom;
      end
      case (rdy_mode)
        0: m_axis.tready = 1'b1;
        1: m_axis.tready = 1'($urandom_range(0, 1));
        default: begin
          m_axis.tready = pat[3-pat_i];
          pat_i = (pat_i + 1) % 4;
        end
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    logic [32:0] e;
    logic [31:0] h, x, pdata;
    logic        plast;
    bit          pstall;
    int          dlen;
    pstall = 0;
    dlen = 0;
    pdata = '0;
    plast = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        cur.delete();
        pstall = 0;
        dlen = 0;
        continue;
      end
      // capture window: busy, not done, not streaming
      if (busy && !done && !m_axis.tvalid) begin
        cur.push_back(adc_data);
        if (cur.size() == NSAMP) begin
          if (hdrq.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_event: got capture expected none");
          end else begin
            h = {8'hA5, hdrq.pop_front()};
            expq.push_back({1'b0, h});
            x = h;
            for (int i = 0; i < NSAMP; i++) begin
              x = x ^ cur[i];
`ifdef CHAN_ACQ_TRAILER_EN
              expq.push_back({1'b0, cur[i]});
`else
              expq.push_back({(i == NSAMP - 1), cur[i]});
`endif
            end
`ifdef CHAN_ACQ_TRAILER_EN
            expq.push_back({1'b1, x});
`endif
          end
          cur.delete();
        end
      end
      if (m_axis.tvalid && cur.size() != 0) begin
        chk("capture_len", 64'(cur.size()), 64'(NSAMP));
        cur.delete();
      end
      if (pstall) begin
        chk("stall_tvalid", m_axis.tvalid, 1);
        chk("stall_tdata", m_axis.tdata, pdata);
        chk("stall_tlast", m_axis.tlast, plast);
      end
      pstall = m_axis.tvalid && !m_axis.tready;
      pdata  = m_axis.tdata;
      plast  = m_axis.tlast;
      if (m_axis.tvalid && m_axis.tready) begin
        if (expq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_word: got %0h expected none",
                   m_axis.tdata);
        end else begin
          e = expq.pop_front();
          chk("tdata", m_axis.tdata, e[31:0]);
          chk("tlast", m_axis.tlast, e[32]);
        end
      end
      if (done) begin
        chk("tvalid_in_done", m_axis.tvalid, 0);
        dlen++;
      end else if (dlen != 0) begin
        chk("done_len", 64'(dlen), 64'(DC));
        dlen = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (!busy && expq.size() == 0 && hdrq.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("drain", ok, 1);
  endtask

  // accepted trigger: pulse w cycles, check entry latency
  task automatic fire(int w);
    int lat = 0;
    bit got = 0;
    wait_idle();
    @(posedge clk);
    #2;
    model_cnt = model_cnt + 24'd1;
    hdrq.push_back(model_cnt);
    acq_trig = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == w) acq_trig = 1'b0;
      if (!got && busy) begin
        got = 1;
        lat = k;
      end
    end
    if (w > 8) begin
      repeat (w - 8) @(posedge clk);
      #1;
      acq_trig = 1'b0;
    end
    chk("trig_latency", (got && lat <= 3), 1);
  endtask

  task automatic wait_tvalid();
    int n = 0;
    while (!m_axis.tvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_axis.tvalid) chk("tvalid_timeout", 0, 1);
  endtask

  initial begin
    bit saw_busy;
    // reset state
    #23;
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", trig_count, 0);
    chk("rst_missed", trig_missed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // basic event, counter samples, full-rate sink
    adc_ctr_mode = 1'b1;
    fire(4);
    wait_drain();
    chk("count_first", trig_count, 24'd1);
    adc_ctr_mode = 1'b0;

    // random backpressure, random pulse widths
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      fire($urandom_range(2, 6));
      wait_drain();
    end
    chk("count_after_rand", trig_count, model_cnt);

    // fixed 1-0-0-1 ready pattern
    rdy_mode = 2;
    fire(3);
    wait_drain();

    // trigger held high through the whole event: no re-trigger
    rdy_mode = 0;
    fire(45);
    wait_drain();
    repeat (10) @(negedge clk);
    chk("held_no_retrig", busy, 0);
    chk("held_missed", trig_missed, 0);
    chk("held_count", trig_count, model_cnt);

    // second edge during SEND_DATA is dropped
    fire(3);
    wait_tvalid();
    repeat (3) @(negedge clk);
    acq_trig = 1'b1;
    repeat (3) @(negedge clk);
    acq_trig = 1'b0;
    wait_drain();
    chk("missed_set", trig_missed, 1);
    chk("missed_count", trig_count, model_cnt);
    repeat (20) @(negedge clk);
    chk("missed_sticky", trig_missed, 1);

    // trig_count wrap
    wait_idle();
    @(negedge clk);
    force dut.trig_cnt_q = 24'hFFFFFF;
    @(posedge clk);
    #1;
    release dut.trig_cnt_q;
    model_cnt = 24'hFFFFFF;
    fire(2);
    wait_drain();
    chk("wrap_count", trig_count, 24'd0);

    // reset mid SEND_DATA, trigger held high across release
    rdy_mode = 1;
    fire(3);
    wait_tvalid();
    repeat (4) @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    acq_trig = 1'b1;
    #1;
    chk("mid_rst_tvalid", m_axis.tvalid, 0);
    chk("mid_rst_tlast", m_axis.tlast, 0);
    chk("mid_rst_tdata", m_axis.tdata, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", trig_count, 0);
    chk("mid_rst_missed", trig_missed, 0);
    expq.delete();
    hdrq.delete();
    model_cnt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    saw_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    chk("no_spurious_trig", saw_busy, 0);
    acq_trig = 1'b0;
    rdy_mode = 0;
    fire(2);
    wait_drain();
    chk("post_rst_count", trig_count, 24'd1);
    chk("post_rst_missed", trig_missed, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
